// File: rtl/pipe_skid_stage_if.sv
// Valid/ready stream bundle for pipe_skid_stage.
// master drives valid/data and samples ready; slave samples valid/data and drives ready.
interface pipe_skid_stage_if #(
   parameter int unsigned WIDTH = 32
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: 2-entry skid buffer between pipeline stages.
// All outputs decode registered state only, so no combinational valid or ready path crosses the stage.
// Optional feature: define PIPE_SKID_FLUSH_EN to add a synchronous flush input.
// up = upstream side (stage is the slave), dn = downstream side (stage is the master).
module pipe_skid_stage #(
   parameter int unsigned WIDTH = 32
) (
   input  logic              clock,
   input  logic              reset,
`ifdef PIPE_SKID_FLUSH_EN
   input  logic              flush,
`endif
   pipe_skid_stage_if.slave  up,
   pipe_skid_stage_if.master dn,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, skid_q;
   logic             ld_main_in, ld_main_skid, ld_skid;
   logic             fin, fout, flush_act;

`ifdef PIPE_SKID_FLUSH_EN
   assign flush_act = flush;
`else
   assign flush_act = 1'b0;
`endif

   assign up.ready = (state_q != FULL);
   assign dn.valid = (state_q != EMPTY);
   assign dn.data  = main_q;

   assign fin  = up.valid & up.ready;
   assign fout = dn.valid & dn.ready;

   // Occupancy decoded from state.
   always_comb begin
      occupancy = 2'd0;
      case (state_q)
         BUSY:    occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   // Next state and data-register load selects.
   always_comb begin
      state_d      = state_q;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (flush_act) begin
         // Coincident accept is dropped; a coincident pop needs no action.
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (fin) begin
                  state_d    = BUSY;
                  ld_main_in = 1'b1;
               end
            end
            BUSY: begin
               if (fin && fout) begin
                  ld_main_in = 1'b1;
               end else if (fin) begin
                  state_d = FULL;
                  ld_skid = 1'b1;
               end else if (fout) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (fout) begin
                  state_d      = BUSY;
                  ld_main_skid = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // State and data registers; reset clears everything, flush only the state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         if (ld_main_in)   main_q <= up.data;
         if (ld_main_skid) main_q <= skid_q;
         if (ld_skid)      skid_q <= up.data;
      end
   end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed checks plus randomized traffic
// compared every cycle against a queue model of the stage contents.
module tb_pipe_skid_stage;
   localparam int unsigned W = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;
   logic [1:0] occupancy;

   int vectors = 0;
   int errors  = 0;

   pipe_skid_stage_if #(.WIDTH(W)) up_if ();
   pipe_skid_stage_if #(.WIDTH(W)) dn_if ();

   pipe_skid_stage #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset     (reset),
`ifdef PIPE_SKID_FLUSH_EN
      .flush     (flush),
`endif
      .up        (up_if),
      .dn        (dn_if),
      .occupancy (occupancy)
   );

   always #5 clock = ~clock;

   // Reference model: ordered list of beats held by the stage.
   logic [W-1:0] q[$];
   bit           mdl_live = 0;
   bit           rst_seen = 0;

   always @(posedge clock) begin
      int  n;
      bit  pop, push;
      if (reset) begin
         q.delete();
         mdl_live = 1;
         rst_seen = 1;
      end else if (mdl_live) begin
         rst_seen = 0;
         n    = q.size();
         pop  = (n > 0) && dn_if.ready;
         push = up_if.valid && (n < 2);
         if (pop) void'(q.pop_front());
         if (flush) q.delete();
         else if (push) q.push_back(up_if.data);
      end
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clock) begin
      if (mdl_live) begin
         chk("in_ready",  {31'd0, up_if.ready}, {31'd0, (q.size() < 2)});
         chk("out_valid", {31'd0, dn_if.valid}, {31'd0, (q.size() > 0)});
         chk("occupancy", {30'd0, occupancy},   q.size());
         if (q.size() > 0) chk("out_data", dn_if.data, q[0]);
         if (rst_seen)     chk("out_data_rst", dn_if.data, '0);
      end
   end

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic expect_lit(input string tag, input logic ov, input logic [1:0] occ,
                             input logic ir, input logic [W-1:0] d, input bit chk_d);
      chk({tag, ".out_valid"}, {31'd0, dn_if.valid}, {31'd0, ov});
      chk({tag, ".occupancy"}, {30'd0, occupancy},   {30'd0, occ});
      chk({tag, ".in_ready"},  {31'd0, up_if.ready}, {31'd0, ir});
      if (chk_d) chk({tag, ".out_data"}, dn_if.data, d);
   endtask

   initial begin
      bit took;
      up_if.valid = 1'b0;
      up_if.data  = '0;
      dn_if.ready = 1'b0;

      // 1: reset for two cycles
      tick(); tick();
      reset = 1'b0;
      expect_lit("rst", 1'b0, 2'd0, 1'b1, 32'h0, 1);

      // 2: streaming with out_ready high
      dn_if.ready = 1'b1;
      up_if.valid = 1'b1; up_if.data = 32'h11; tick();
      expect_lit("s11", 1'b1, 2'd1, 1'b1, 32'h11, 1);
      up_if.data = 32'h22; tick();
      expect_lit("s22", 1'b1, 2'd1, 1'b1, 32'h22, 1);
      up_if.data = 32'h33; tick();
      up_if.valid = 1'b0;
      expect_lit("s33", 1'b1, 2'd1, 1'b1, 32'h33, 1);
      tick();
      expect_lit("sdrain", 1'b0, 2'd0, 1'b1, 32'h0, 0);

      // 3/4: fill under back-pressure, then offer a beat while full
      dn_if.ready = 1'b0;
      up_if.valid = 1'b1; up_if.data = 32'hA; tick();
      expect_lit("fillA", 1'b1, 2'd1, 1'b1, 32'hA, 1);
      up_if.data = 32'hB; tick();
      expect_lit("fillB", 1'b1, 2'd2, 1'b0, 32'hA, 1);
      up_if.data = 32'hC;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_lit("fullC", 1'b1, 2'd2, 1'b0, 32'hA, 1);
      end
      up_if.valid = 1'b0; dn_if.ready = 1'b1; tick();
      expect_lit("popA", 1'b1, 2'd1, 1'b1, 32'hB, 1);
      tick();
      expect_lit("popB", 1'b0, 2'd0, 1'b1, 32'h0, 0);

      // 5: reset while full with out_ready high
      dn_if.ready = 1'b0;
      up_if.valid = 1'b1; up_if.data = 32'hE; tick();
      up_if.data = 32'hF; tick();
      expect_lit("fillEF", 1'b1, 2'd2, 1'b0, 32'hE, 1);
      up_if.valid = 1'b0; dn_if.ready = 1'b1; reset = 1'b1; tick();
      reset = 1'b0;
      expect_lit("rstfull", 1'b0, 2'd0, 1'b1, 32'h0, 1);

`ifdef PIPE_SKID_FLUSH_EN
      // 6: flush while busy with a coincident offered beat
      dn_if.ready = 1'b0;
      up_if.valid = 1'b1; up_if.data = 32'h5; tick();
      expect_lit("busy5", 1'b1, 2'd1, 1'b1, 32'h5, 1);
      flush = 1'b1; up_if.data = 32'hD; tick();
      flush = 1'b0; up_if.valid = 1'b0;
      expect_lit("flush", 1'b0, 2'd0, 1'b1, 32'h0, 0);
      dn_if.ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_lit("noD", 1'b0, 2'd0, 1'b1, 32'h0, 0);
      end
`endif

      // Randomized traffic; upstream holds an offered beat until it transfers
      up_if.valid = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         int bias;
         bias = (i / 500) % 4;
         if (!(up_if.valid && !took) || reset) begin
            up_if.valid = ($urandom_range(0, 3) != 0);
            up_if.data  = $urandom;
         end
         dn_if.ready = ($urandom_range(0, 3) < (bias + 1));
         reset = ($urandom_range(0, 99) == 0);
`ifdef PIPE_SKID_FLUSH_EN
         flush = ($urandom_range(0, 39) == 0);
`endif
         took = up_if.valid && up_if.ready && !reset && !flush;
         tick();
      end
      reset = 1'b0;
      flush = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
